// File: rtl/quad_step_decoder.sv
// Quadrature A/B front-end: two-flop synchronisers, per-channel persistence filters,
// Gray-code step decode into single-cycle up/down pulses and a sticky illegal-transition flag.
module quad_step_decoder #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clr,
    output logic step_en,
    output logic step_up,
    output logic step_dn,
    output logic dir,
    output logic err
);

    localparam int unsigned FCW = $clog2(FILT_LEN + 1);
    localparam logic [FCW-1:0] CNT_LAST = FCW'(FILT_LEN - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q,    state_d;
    logic [1:0]     init_cnt_q, init_cnt_d;
    logic [1:0]     sync_a_q,   sync_a_d;
    logic [1:0]     sync_b_q,   sync_b_d;
    logic [FCW-1:0] cnt_a_q,    cnt_a_d;
    logic [FCW-1:0] cnt_b_q,    cnt_b_d;
    logic           filt_a_q,   filt_a_d;
    logic           filt_b_q,   filt_b_d;
    logic [1:0]     prev_q,     prev_d;
    logic           step_up_q,  step_up_d;
    logic           step_dn_q,  step_dn_d;
    logic           step_en_q,  step_en_d;
    logic           dir_q,      dir_d;
    logic           err_q,      err_d;

    logic [1:0]     cur;
    logic [1:0]     diff;
    logic           fwd;

    assign cur  = {filt_a_q, filt_b_q};
    assign diff = cur ^ prev_q;
    // In the Gray cycle 00->10->11->01 the new A always differs from the old B.
    assign fwd  = cur[1] ^ prev_q[0];

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        sync_a_d   = {sync_a_q[0], a_in};
        sync_b_d   = {sync_b_q[0], b_in};
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        filt_a_d   = filt_a_q;
        filt_b_d   = filt_b_q;
        prev_d     = prev_q;
        step_up_d  = 1'b0;
        step_dn_d  = 1'b0;
        dir_d      = dir_q;
        err_d      = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                // Wait for the synchronisers to fill, then adopt the pin levels silently.
                if (init_cnt_q == 2'd2) begin
                    filt_a_d = sync_a_q[1];
                    filt_b_d = sync_b_q[1];
                    prev_d   = {sync_a_q[1], sync_b_q[1]};
                    cnt_a_d  = '0;
                    cnt_b_d  = '0;
                    state_d  = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end

            ST_RUN: begin
                if (sync_a_q[1] == filt_a_q) begin
                    cnt_a_d = '0;
                end else if (cnt_a_q == CNT_LAST) begin
                    filt_a_d = sync_a_q[1];
                    cnt_a_d  = '0;
                end else begin
                    cnt_a_d = cnt_a_q + FCW'(1);
                end

                if (sync_b_q[1] == filt_b_q) begin
                    cnt_b_d = '0;
                end else if (cnt_b_q == CNT_LAST) begin
                    filt_b_d = sync_b_q[1];
                    cnt_b_d  = '0;
                end else begin
                    cnt_b_d = cnt_b_q + FCW'(1);
                end

                prev_d = cur;
                if (diff == 2'b11) begin
                    err_d = 1'b1;
                end else if ((diff != 2'b00) && en) begin
                    step_up_d = fwd;
                    step_dn_d = ~fwd;
                    dir_d     = fwd;
                end
            end

            default: state_d = ST_INIT;
        endcase

        step_en_d = step_up_d | step_dn_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            filt_a_q   <= 1'b0;
            filt_b_q   <= 1'b0;
            prev_q     <= '0;
            step_up_q  <= 1'b0;
            step_dn_q  <= 1'b0;
            step_en_q  <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            filt_a_q   <= filt_a_d;
            filt_b_q   <= filt_b_d;
            prev_q     <= prev_d;
            step_up_q  <= step_up_d;
            step_dn_q  <= step_dn_d;
            step_en_q  <= step_en_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign step_up = step_up_q;
    assign step_dn = step_dn_q;
    assign step_en = step_en_q;
    assign dir     = dir_q;
    assign err     = err_q;

endmodule
